blake2_block_ctrl: RTL and testbench

//  Sequences one BLAKE2s hash from the I/O interface to the compression core.
//  - Assembles incoming message bytes into a 64-byte block buffer.
//  - Maintains the byte counter t and decides when a block is final.
//  - Hands each block to the compression core using a start/done handshake.
//  - After the final compression, streams nn digest bytes out.
//  - Sits between io_intf (input side) and the compression round engine.

---
 rtl/blake2_pkg.sv | 24 ++
 rtl/blake2_msg_buf.sv | 30 +++
 rtl/blake2_block_ctrl.sv | 161 ++++++++++++++++
 tb/tb_blake2_block_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared types and constants for the BLAKE2s block sequencer.
package blake2_pkg;

    localparam int BLOCK_BYTES     = 64;
    localparam int H_BYTES         = 32;
    localparam int KEY_BLOCK_BYTES = 64;
    localparam int T_W             = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_COMPRESS,
        ST_OUTPUT
    } state_t;

    // A zero or oversized digest request falls back to the full 32-byte digest.
    function automatic logic [5:0] calc_nn_eff(input logic [7:0] nn);
        if (nn == 8'd0 || nn > 8'(H_BYTES))
            return 6'(H_BYTES);
        else
            return 6'(nn);
    endfunction

endpackage

// File: rtl/blake2_msg_buf.sv
// 64-byte message block buffer: byte writes by index, one-cycle clear, flat read.
module blake2_msg_buf
    import blake2_pkg::*;
(
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       clr,
    input  logic                       we,
    input  logic [5:0]                 idx,
    input  logic [7:0]                 wdata,
    output logic [8*BLOCK_BYTES-1:0]   m
);

    logic [7:0] mem [BLOCK_BYTES];

    // Clear wins over a write so a restart never leaks a stale byte.
    always_ff @(posedge clk) begin
        if (!nreset || clr) begin
            for (int i = 0; i < BLOCK_BYTES; i++)
                mem[i] <= 8'd0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_flat
        assign m[8*g +: 8] = mem[g];
    end

endmodule

// File: rtl/blake2_block_ctrl.sv
// Sequences one BLAKE2s hash: fills blocks, drives the compression handshake,
// then serializes the digest.
module blake2_block_ctrl
    import blake2_pkg::*;
(
    input  logic           clk,
    input  logic           nreset,
    input  logic           start_i,
    input  logic [7:0]     kk_i,
    input  logic [7:0]     nn_i,
    input  logic [63:0]    ll_i,
    input  logic           data_v_i,
    input  logic [7:0]     data_i,
    input  logic [5:0]     data_idx_i,
    output logic           cmp_start_o,
    output logic           cmp_init_o,
    output logic           cmp_final_o,
    output logic [63:0]    cmp_t_o,
    output logic [511:0]   m_o,
    input  logic           cmp_done_i,
    input  logic [255:0]   h_i,
    output logic           hash_v_o,
    output logic [7:0]     hash_o,
    output logic           hash_last_o,
    output logic           busy_o,
    output logic           overflow_o
);

    localparam logic [T_W:0]   KEY_ADD = (T_W+1)'(KEY_BLOCK_BYTES);
    localparam logic [T_W-1:0] T_MAX   = {T_W{1'b1}};
    localparam logic [5:0]     IDX_END = 6'(BLOCK_BYTES - 1);

    state_t         state;
    logic [T_W-1:0] t;
    logic [T_W:0]   ll_tot;
    logic [5:0]     nn_eff;
    logic           first;
    logic [5:0]     k;
    logic [255:0]   h_reg;

    logic [T_W:0]   start_ll_tot;
    logic [T_W-1:0] t_inc;
    logic           accept;
    logic           last_byte;
    logic           block_close;
    logic           buf_clr;

    // ll_tot is one bit wider than ll_i so the key block can never wrap it.
    assign start_ll_tot = {1'b0, ll_i} + ((kk_i != 8'd0) ? KEY_ADD : '0);
    assign t_inc        = (t == T_MAX) ? t : t + T_W'(1);
    assign accept       = (state == ST_FILL) && data_v_i && !start_i;
    assign last_byte    = ({1'b0, t_inc} == ll_tot);
    assign block_close  = accept && ((data_idx_i == IDX_END) || last_byte);
    assign buf_clr      = start_i
                        || ((state == ST_COMPRESS) && cmp_done_i && !cmp_final_o);
    assign busy_o       = (state != ST_IDLE);

    blake2_msg_buf u_msg_buf (
        .clk    (clk),
        .nreset (nreset),
        .clr    (buf_clr),
        .we     (accept),
        .idx    (data_idx_i),
        .wdata  (data_i),
        .m      (m_o)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            t           <= '0;
            ll_tot      <= '0;
            nn_eff      <= '0;
            first       <= 1'b0;
            k           <= '0;
            h_reg       <= '0;
            cmp_start_o <= 1'b0;
            cmp_init_o  <= 1'b0;
            cmp_final_o <= 1'b0;
            cmp_t_o     <= '0;
            hash_v_o    <= 1'b0;
            hash_o      <= '0;
            hash_last_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            cmp_start_o <= 1'b0;
            if (start_i) begin
                ll_tot      <= start_ll_tot;
                nn_eff      <= calc_nn_eff(nn_i);
                t           <= '0;
                first       <= 1'b1;
                k           <= '0;
                overflow_o  <= 1'b0;
                hash_v_o    <= 1'b0;
                hash_o      <= '0;
                hash_last_o <= 1'b0;
                cmp_t_o     <= '0;
                // An empty message still needs one (all-padding) final compression.
                if (start_ll_tot == '0) begin
                    state       <= ST_COMPRESS;
                    cmp_start_o <= 1'b1;
                    cmp_init_o  <= 1'b1;
                    cmp_final_o <= 1'b1;
                end else begin
                    state       <= ST_FILL;
                    cmp_init_o  <= 1'b0;
                    cmp_final_o <= 1'b0;
                end
            end else begin
                case (state)
                    ST_FILL: begin
                        if (data_v_i) begin
                            t <= t_inc;
                            if (block_close) begin
                                state       <= ST_COMPRESS;
                                cmp_start_o <= 1'b1;
                                cmp_init_o  <= first;
                                cmp_final_o <= last_byte;
                                cmp_t_o     <= t_inc;
                            end
                        end
                    end
                    ST_COMPRESS: begin
                        if (data_v_i)
                            overflow_o <= 1'b1;
                        if (cmp_done_i) begin
                            first <= 1'b0;
                            if (cmp_final_o) begin
                                // Byte 0 comes straight from h_i; the rest from the captured copy.
                                state       <= ST_OUTPUT;
                                h_reg       <= h_i;
                                hash_v_o    <= 1'b1;
                                hash_o      <= h_i[7:0];
                                hash_last_o <= (nn_eff == 6'd1);
                                k           <= 6'd1;
                            end else begin
                                state <= ST_FILL;
                            end
                        end
                    end
                    ST_OUTPUT: begin
                        if (data_v_i)
                            overflow_o <= 1'b1;
                        if (hash_last_o) begin
                            state       <= ST_IDLE;
                            hash_v_o    <= 1'b0;
                            hash_o      <= '0;
                            hash_last_o <= 1'b0;
                        end else begin
                            hash_o      <= h_reg[{k[4:0], 3'b000} +: 8];
                            hash_last_o <= (k == nn_eff - 6'd1);
                            k           <= k + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blake2_block_ctrl.sv
// Directed self-checking bench for blake2_block_ctrl.
module tb_blake2_block_ctrl;

    logic           clk = 1'b0;
    logic           nreset;
    logic           start_i;
    logic [7:0]     kk_i;
    logic [7:0]     nn_i;
    logic [63:0]    ll_i;
    logic           data_v_i;
    logic [7:0]     data_i;
    logic [5:0]     data_idx_i;
    logic           cmp_start_o;
    logic           cmp_init_o;
    logic           cmp_final_o;
    logic [63:0]    cmp_t_o;
    logic [511:0]   m_o;
    logic           cmp_done_i;
    logic [255:0]   h_i;
    logic           hash_v_o;
    logic [7:0]     hash_o;
    logic           hash_last_o;
    logic           busy_o;
    logic           overflow_o;

    int errors = 0;
    int checks = 0;

    logic [255:0] h_pat;
    logic [511:0] exp_m;

    blake2_block_ctrl dut (
        .clk         (clk),
        .nreset      (nreset),
        .start_i     (start_i),
        .kk_i        (kk_i),
        .nn_i        (nn_i),
        .ll_i        (ll_i),
        .data_v_i    (data_v_i),
        .data_i      (data_i),
        .data_idx_i  (data_idx_i),
        .cmp_start_o (cmp_start_o),
        .cmp_init_o  (cmp_init_o),
        .cmp_final_o (cmp_final_o),
        .cmp_t_o     (cmp_t_o),
        .m_o         (m_o),
        .cmp_done_i  (cmp_done_i),
        .h_i         (h_i),
        .hash_v_o    (hash_v_o),
        .hash_o      (hash_o),
        .hash_last_o (hash_last_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] kk, input logic [7:0] nn, input logic [63:0] ll);
        start_i = 1'b1;
        kk_i    = kk;
        nn_i    = nn;
        ll_i    = ll;
        tick();
        start_i = 1'b0;
    endtask

    task automatic sendByte(input logic [5:0] idx, input logic [7:0] d);
        data_v_i   = 1'b1;
        data_idx_i = idx;
        data_i     = d;
        tick();
        data_v_i   = 1'b0;
    endtask

    task automatic doneWith(input logic [255:0] h);
        cmp_done_i = 1'b1;
        h_i        = h;
        tick();
        cmp_done_i = 1'b0;
    endtask

    task automatic checkCmp(input string tag, input logic init, input logic fin, input logic [63:0] t);
        checkOutput({tag, " start"}, cmp_start_o, 1'b1);
        checkOutput({tag, " init"}, cmp_init_o, init);
        checkOutput({tag, " final"}, cmp_final_o, fin);
        checkOutput({tag, " t"}, cmp_t_o, t);
    endtask

    task automatic checkStream(input string tag, input int n, input logic [255:0] h);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, " hash_v"}, hash_v_o, 1'b1);
            checkOutput({tag, " hash_o"}, hash_o, h[8*i +: 8]);
            checkOutput({tag, " hash_last"}, hash_last_o, (i == n - 1));
            tick();
        end
        checkOutput({tag, " hash_v end"}, hash_v_o, 1'b0);
        checkOutput({tag, " busy end"}, busy_o, 1'b0);
    endtask

    initial begin
        nreset     = 1'b0;
        start_i    = 1'b0;
        kk_i       = '0;
        nn_i       = '0;
        ll_i       = '0;
        data_v_i   = 1'b0;
        data_i     = '0;
        data_idx_i = '0;
        cmp_done_i = 1'b0;
        h_i        = '0;
        for (int i = 0; i < 32; i++)
            h_pat[8*i +: 8] = 8'(i * 7 + 3);

        tick();
        tick();
        checkOutput("reset busy", busy_o, 1'b0);
        checkOutput("reset cmp_start", cmp_start_o, 1'b0);
        checkOutput("reset hash_v", hash_v_o, 1'b0);
        checkOutput("reset overflow", overflow_o, 1'b0);
        checkOutput("reset m_o", m_o, 512'd0);
        checkOutput("reset cmp_t", cmp_t_o, 64'd0);
        nreset = 1'b1;
        tick();

        // "abc", single final block
        applyStimulus(8'd0, 8'd32, 64'd3);
        checkOutput("abc busy", busy_o, 1'b1);
        checkOutput("abc no early start", cmp_start_o, 1'b0);
        sendByte(6'd0, 8'h61);
        sendByte(6'd1, 8'h62);
        sendByte(6'd2, 8'h63);
        checkCmp("abc", 1'b1, 1'b1, 64'd3);
        checkOutput("abc m_o", m_o, 512'h636261);
        tick();
        checkOutput("abc start pulse", cmp_start_o, 1'b0);
        checkOutput("abc m held", m_o, 512'h636261);
        doneWith(h_pat);
        checkStream("abc", 32, h_pat);

        // empty message, short digest
        applyStimulus(8'd0, 8'd4, 64'd0);
        checkCmp("empty", 1'b1, 1'b1, 64'd0);
        checkOutput("empty m_o", m_o, 512'd0);
        doneWith(~h_pat);
        checkStream("nn4", 4, ~h_pat);

        // two full blocks, last full block is final
        applyStimulus(8'd0, 8'd16, 64'd128);
        exp_m = '0;
        for (int i = 0; i < 64; i++) begin
            sendByte(6'(i), 8'(i));
            exp_m[8*i +: 8] = 8'(i);
        end
        checkCmp("ll128 b0", 1'b1, 1'b0, 64'd64);
        checkOutput("ll128 b0 m_o", m_o, exp_m);
        doneWith(h_pat);
        checkOutput("ll128 back to fill", busy_o, 1'b1);
        checkOutput("ll128 no hash", hash_v_o, 1'b0);
        checkOutput("ll128 buf cleared", m_o, 512'd0);
        for (int i = 0; i < 64; i++) begin
            sendByte(6'(i), 8'(i + 100));
            exp_m[8*i +: 8] = 8'(i + 100);
        end
        checkCmp("ll128 b1", 1'b0, 1'b1, 64'd128);
        checkOutput("ll128 b1 m_o", m_o, exp_m);
        doneWith(h_pat);
        checkStream("nn16", 16, h_pat);

        // keyed: key block then one message byte
        applyStimulus(8'd16, 8'd32, 64'd1);
        for (int i = 0; i < 64; i++)
            sendByte(6'(i), (i < 16) ? 8'(i + 1) : 8'd0);
        checkCmp("key b0", 1'b1, 1'b0, 64'd64);
        doneWith(h_pat);
        sendByte(6'd0, 8'h55);
        checkCmp("key b1", 1'b0, 1'b1, 64'd65);
        checkOutput("key b1 m_o", m_o, 512'h55);

        // restart together with a stale done
        start_i    = 1'b1;
        kk_i       = 8'd0;
        nn_i       = 8'd0;
        ll_i       = 64'd2;
        cmp_done_i = 1'b1;
        h_i        = h_pat;
        tick();
        start_i    = 1'b0;
        cmp_done_i = 1'b0;
        checkOutput("restart hash_v", hash_v_o, 1'b0);
        checkOutput("restart busy", busy_o, 1'b1);
        checkOutput("restart cmp_start", cmp_start_o, 1'b0);
        checkOutput("restart m_o", m_o, 512'd0);

        // overflow while compressing; nn=0 gives 32 bytes
        sendByte(6'd0, 8'h11);
        sendByte(6'd1, 8'h22);
        checkCmp("ovf", 1'b1, 1'b1, 64'd2);
        sendByte(6'd2, 8'h33);
        checkOutput("ovf flag", overflow_o, 1'b1);
        checkOutput("ovf m_o", m_o, 512'h2211);
        doneWith(~h_pat);
        checkStream("nn0", 32, ~h_pat);
        checkOutput("ovf sticky", overflow_o, 1'b1);

        // start with simultaneous byte: byte dropped, overflow cleared; nn=40 gives 32
        data_v_i   = 1'b1;
        data_idx_i = 6'd0;
        data_i     = 8'h77;
        applyStimulus(8'd0, 8'd40, 64'd1);
        data_v_i   = 1'b0;
        checkOutput("start+data overflow", overflow_o, 1'b0);
        checkOutput("start+data m_o", m_o, 512'd0);
        sendByte(6'd0, 8'h99);
        checkCmp("nn40", 1'b1, 1'b1, 64'd1);
        checkOutput("nn40 m_o", m_o, 512'h99);
        doneWith(h_pat);
        checkStream("nn40", 32, h_pat);

        // data in IDLE is ignored
        sendByte(6'd0, 8'hAB);
        checkOutput("idle overflow", overflow_o, 1'b0);
        checkOutput("idle busy", busy_o, 1'b0);

        // reset during OUTPUT aborts the stream
        applyStimulus(8'd0, 8'd32, 64'd1);
        sendByte(6'd0, 8'h01);
        doneWith(h_pat);
        tick();
        checkOutput("abort pre hash_v", hash_v_o, 1'b1);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        checkOutput("abort hash_v", hash_v_o, 1'b0);
        checkOutput("abort busy", busy_o, 1'b0);
        tick();
        checkOutput("abort stays idle hash_v", hash_v_o, 1'b0);
        checkOutput("abort no cmp_start", cmp_start_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
